// File: rtl/ctrl_pkg.sv
// Shared constants for the tiny-CPU control sequencer: field widths,
// FSM state encoding, opcode map and ALU operation codes.
// Optional build macro used by the sequencer: CTRL_ILLEGAL_TRAP_EN.
package ctrl_pkg;

    localparam int INST_W = 8;
    localparam int OPC_W  = 4;

    // FSM state encoding (3 bits, legacy-compatible constants)
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_MEM_RD = 3'd2;
    localparam logic [2:0] ST_MEM_WR = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    // Opcode map, instruction bits [7:4]
    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_STA = 4'h2;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h3;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h7;
    localparam logic [OPC_W-1:0] OP_OUT = 4'h8;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    // ALU operation select
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Control bus between the sequencer (master) and the CPU datapath (slave).
// The illegal flag exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface ctrl_sequencer_if;
    import ctrl_pkg::*;

    logic [INST_W-1:0] ir_inst;
    logic              mem_ready;
    logic              zero_flag;
    logic              ir_load;
    logic              pc_inc;
    logic              pc_load;
    logic              addr_sel;
    logic              mem_rd;
    logic              mem_wr;
    logic              acc_load;
    logic              acc_src;
    logic [1:0]        alu_op;
    logic              out_load;
    logic              halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic              illegal;

    modport master (
        input  ir_inst, mem_ready, zero_flag,
        output ir_load, pc_inc, pc_load, addr_sel, mem_rd, mem_wr,
               acc_load, acc_src, alu_op, out_load, halted, illegal
    );

    modport slave (
        output ir_inst, mem_ready, zero_flag,
        input  ir_load, pc_inc, pc_load, addr_sel, mem_rd, mem_wr,
               acc_load, acc_src, alu_op, out_load, halted, illegal
    );
`else
    modport master (
        input  ir_inst, mem_ready, zero_flag,
        output ir_load, pc_inc, pc_load, addr_sel, mem_rd, mem_wr,
               acc_load, acc_src, alu_op, out_load, halted
    );

    modport slave (
        output ir_inst, mem_ready, zero_flag,
        input  ir_load, pc_inc, pc_load, addr_sel, mem_rd, mem_wr,
               acc_load, acc_src, alu_op, out_load, halted
    );
`endif

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: maps the opcode field to an
// instruction class and the ALU operation used during MEM_RD.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             is_mem_rd,
    output logic             is_mem_wr,
    output logic             is_imm,
    output logic             is_jmp,
    output logic             is_jz,
    output logic             is_out,
    output logic             is_hlt,
    output logic             is_illegal,
    output logic [1:0]       alu_op
);

    // One-hot class flags per opcode; 9-E fall through to illegal
    always_comb begin
        is_mem_rd  = 1'b0;
        is_mem_wr  = 1'b0;
        is_imm     = 1'b0;
        is_jmp     = 1'b0;
        is_jz      = 1'b0;
        is_out     = 1'b0;
        is_hlt     = 1'b0;
        is_illegal = 1'b0;
        alu_op     = ALU_PASS;
        case (opcode)
            OP_NOP: ;
            OP_LDA: is_mem_rd = 1'b1;
            OP_ADD: begin
                is_mem_rd = 1'b1;
                alu_op    = ALU_ADD;
            end
            OP_SUB: begin
                is_mem_rd = 1'b1;
                alu_op    = ALU_SUB;
            end
            OP_STA: is_mem_wr = 1'b1;
            OP_LDI: is_imm    = 1'b1;
            OP_JMP: is_jmp    = 1'b1;
            OP_JZ:  is_jz     = 1'b1;
            OP_OUT: is_out    = 1'b1;
            OP_HLT: is_hlt    = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute control FSM for the tiny CPU. Holds the state
// register and drives all datapath strobes combinationally.
// Build option CTRL_ILLEGAL_TRAP_EN: opcodes 9-E halt and raise illegal;
// without it they execute as NOP.
module ctrl_sequencer #(
    parameter int INST_W = ctrl_pkg::INST_W,
    parameter int OPC_W  = ctrl_pkg::OPC_W
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_sequencer_if.master  bus
);
    import ctrl_pkg::ST_FETCH;
    import ctrl_pkg::ST_DECODE;
    import ctrl_pkg::ST_MEM_RD;
    import ctrl_pkg::ST_MEM_WR;
    import ctrl_pkg::ST_HALT;
    import ctrl_pkg::ALU_PASS;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [OPC_W-1:0] opcode;
    logic             dec_mem_rd;
    logic             dec_mem_wr;
    logic             dec_imm;
    logic             dec_jmp;
    logic             dec_jz;
    logic             dec_out;
    logic             dec_hlt;
    logic             dec_illegal;
    logic [1:0]       dec_alu_op;
    logic             unused_operand;

    assign opcode         = bus.ir_inst[INST_W-1 -: OPC_W];
    assign unused_operand = ^bus.ir_inst[INST_W-OPC_W-1:0];

    ctrl_decode u_decode (
        .opcode     (opcode),
        .is_mem_rd  (dec_mem_rd),
        .is_mem_wr  (dec_mem_wr),
        .is_imm     (dec_imm),
        .is_jmp     (dec_jmp),
        .is_jz      (dec_jz),
        .is_out     (dec_out),
        .is_hlt     (dec_hlt),
        .is_illegal (dec_illegal),
        .alu_op     (dec_alu_op)
    );

    // State register; reset abandons any access in progress
    always_ff @(posedge clk) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_nxt;
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky trap flag, set on the DECODE->HALT transition for 9-E
    always_ff @(posedge clk) begin
        if (rst)                                    illegal_q <= 1'b0;
        else if (state == ST_DECODE && dec_illegal) illegal_q <= 1'b1;
    end

    assign bus.illegal = illegal_q & ~rst;
`endif

    // Next-state and strobe generation; everything held low during reset
    always_comb begin
        state_nxt    = state;
        bus.ir_load  = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.pc_load  = 1'b0;
        bus.addr_sel = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.acc_load = 1'b0;
        bus.acc_src  = 1'b0;
        bus.alu_op   = ALU_PASS;
        bus.out_load = 1'b0;
        bus.halted   = 1'b0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    bus.mem_rd = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_load = 1'b1;
                        bus.pc_inc  = 1'b1;
                        state_nxt   = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_nxt = ST_FETCH;
                    if (dec_mem_rd) begin
                        state_nxt = ST_MEM_RD;
                    end else if (dec_mem_wr) begin
                        state_nxt = ST_MEM_WR;
                    end else if (dec_imm) begin
                        bus.acc_load = 1'b1;
                        bus.acc_src  = 1'b1;
                    end else if (dec_jmp) begin
                        bus.pc_load = 1'b1;
                    end else if (dec_jz) begin
                        bus.pc_load = bus.zero_flag;
                    end else if (dec_out) begin
                        bus.out_load = 1'b1;
                    end else if (dec_hlt) begin
                        state_nxt = ST_HALT;
                    end else if (dec_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_nxt = ST_HALT;
`else
                        state_nxt = ST_FETCH;
`endif
                    end
                end
                ST_MEM_RD: begin
                    bus.mem_rd   = 1'b1;
                    bus.addr_sel = 1'b1;
                    bus.alu_op   = dec_alu_op;
                    if (bus.mem_ready) begin
                        bus.acc_load = 1'b1;
                        state_nxt    = ST_FETCH;
                    end
                end
                ST_MEM_WR: begin
                    bus.mem_wr   = 1'b1;
                    bus.addr_sel = 1'b1;
                    if (bus.mem_ready) state_nxt = ST_FETCH;
                end
                ST_HALT: begin
                    bus.halted = 1'b1;
                end
                default: state_nxt = ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: a table of per-cycle vectors
// plus hand-written sequences for reset-mid-access, halt and illegal.
// Output vector order: {ir_load, pc_inc, pc_load, addr_sel, mem_rd,
// mem_wr, acc_load, acc_src, alu_op[1:0], out_load, halted}.
module tb_ctrl_sequencer;

    typedef struct {
        logic        rst;
        logic [7:0]  ir;
        logic        rdy;
        logic        z;
        logic [11:0] exp;
        logic        exp_ill;
    } vec_t;

    localparam logic [11:0] E_NONE  = 12'b0000_0000_0000;
    localparam logic [11:0] E_FETCH = 12'b1100_1000_0000;
    localparam logic [11:0] E_FWAIT = 12'b0000_1000_0000;
    localparam logic [11:0] E_LDI   = 12'b0000_0011_0000;
    localparam logic [11:0] E_ADDW  = 12'b0001_1000_0100;
    localparam logic [11:0] E_ADDR  = 12'b0001_1010_0100;
    localparam logic [11:0] E_SUBR  = 12'b0001_1010_1000;
    localparam logic [11:0] E_LDAR  = 12'b0001_1010_0000;
    localparam logic [11:0] E_STA   = 12'b0001_0100_0000;
    localparam logic [11:0] E_PCLD  = 12'b0010_0000_0000;
    localparam logic [11:0] E_OUT   = 12'b0000_0000_0010;
    localparam logic [11:0] E_HALT  = 12'b0000_0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t sb[$];
    vec_t vecs[$];

    ctrl_sequencer_if bus();

    ctrl_sequencer #(.INST_W(8), .OPC_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [7:0] ir,
                                input logic rdy, input logic z,
                                input logic [11:0] exp, input logic ill);
        vec_t v;
        v.rst = r; v.ir = ir; v.rdy = rdy; v.z = z; v.exp = exp; v.exp_ill = ill;
        return v;
    endfunction

    function automatic logic [11:0] outs();
        return {bus.ir_load, bus.pc_inc, bus.pc_load, bus.addr_sel, bus.mem_rd,
                bus.mem_wr, bus.acc_load, bus.acc_src, bus.alu_op,
                bus.out_load, bus.halted};
    endfunction

    // Drive one cycle of inputs, queue its expectation, then sample and compare
    task automatic step(input vec_t v, input string nm);
        vec_t e;
        logic [11:0] got;
        @(negedge clk);
        rst           = v.rst;
        bus.ir_inst   = v.ir;
        bus.mem_ready = v.rdy;
        bus.zero_flag = v.z;
        sb.push_back(v);
        #1;
        e   = sb.pop_front();
        got = outs();
        n_checks++;
        if (got === e.exp) n_pass++;
        else $display("FAIL %s: outputs got %b expected %b", nm, got, e.exp);
        n_checks++;
        if (!(bus.pc_inc && bus.pc_load) && !(bus.mem_rd && bus.mem_wr)) n_pass++;
        else $display("FAIL %s_excl: pc_inc/pc_load=%b%b mem_rd/mem_wr=%b%b expected not both",
                      nm, bus.pc_inc, bus.pc_load, bus.mem_rd, bus.mem_wr);
`ifdef CTRL_ILLEGAL_TRAP_EN
        n_checks++;
        if (bus.illegal === e.exp_ill) n_pass++;
        else $display("FAIL %s_illegal: got %b expected %b", nm, bus.illegal, e.exp_ill);
`endif
    endtask

    initial begin
        bus.ir_inst   = 8'h00;
        bus.mem_ready = 1'b0;
        bus.zero_flag = 1'b0;

        // Reset, then LDI / ADD with waits / JZ / STA / OUT / JMP / SUB / LDA / NOP
        vecs.push_back(mk(1, 8'h00, 0, 0, E_NONE,  0));
        vecs.push_back(mk(1, 8'h00, 1, 0, E_NONE,  0));
        vecs.push_back(mk(0, 8'h00, 1, 0, E_FETCH, 0));
        vecs.push_back(mk(0, 8'h57, 1, 0, E_LDI,   0));
        vecs.push_back(mk(0, 8'h57, 0, 0, E_FWAIT, 0));
        vecs.push_back(mk(0, 8'h57, 1, 0, E_FETCH, 0));
        vecs.push_back(mk(0, 8'h3A, 0, 0, E_NONE,  0));
        vecs.push_back(mk(0, 8'h3A, 0, 0, E_ADDW,  0));
        vecs.push_back(mk(0, 8'h3A, 0, 0, E_ADDW,  0));
        vecs.push_back(mk(0, 8'h3A, 1, 0, E_ADDR,  0));
        vecs.push_back(mk(0, 8'h3A, 1, 0, E_FETCH, 0));
        vecs.push_back(mk(0, 8'h7C, 1, 0, E_NONE,  0));
        vecs.push_back(mk(0, 8'h7C, 1, 1, E_FETCH, 0));
        vecs.push_back(mk(0, 8'h7C, 1, 1, E_PCLD,  0));
        vecs.push_back(mk(0, 8'h7C, 1, 0, E_FETCH, 0));
        vecs.push_back(mk(0, 8'h25, 1, 0, E_NONE,  0));
        vecs.push_back(mk(0, 8'h25, 0, 0, E_STA,   0));
        vecs.push_back(mk(0, 8'h25, 1, 0, E_STA,   0));
        vecs.push_back(mk(0, 8'h25, 1, 0, E_FETCH, 0));
        vecs.push_back(mk(0, 8'h83, 1, 0, E_OUT,   0));
        vecs.push_back(mk(0, 8'h83, 1, 0, E_FETCH, 0));
        vecs.push_back(mk(0, 8'h6E, 1, 0, E_PCLD,  0));
        vecs.push_back(mk(0, 8'h6E, 1, 0, E_FETCH, 0));
        vecs.push_back(mk(0, 8'h41, 1, 0, E_NONE,  0));
        vecs.push_back(mk(0, 8'h41, 1, 0, E_SUBR,  0));
        vecs.push_back(mk(0, 8'h41, 1, 0, E_FETCH, 0));
        vecs.push_back(mk(0, 8'h19, 1, 1, E_NONE,  0));
        vecs.push_back(mk(0, 8'h19, 1, 1, E_LDAR,  0));
        vecs.push_back(mk(0, 8'h19, 1, 0, E_FETCH, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, E_NONE,  0));
        vecs.push_back(mk(0, 8'h00, 0, 0, E_FWAIT, 0));

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // Reset for two cycles in the middle of a MEM_RD wait
        step(mk(0, 8'h00, 1, 0, E_FETCH, 0), "rstmid_fetch");
        step(mk(0, 8'h1F, 0, 0, E_NONE,  0), "rstmid_decode");
        step(mk(0, 8'h1F, 0, 0, 12'b0001_1000_0000, 0), "rstmid_memrd");
        step(mk(1, 8'h1F, 1, 0, E_NONE,  0), "rstmid_rst0");
        step(mk(1, 8'h1F, 1, 0, E_NONE,  0), "rstmid_rst1");
        step(mk(0, 8'h1F, 0, 0, E_FWAIT, 0), "rstmid_release");

        // STA with a wait, then HLT held for 20 cycles
        step(mk(0, 8'h00, 1, 0, E_FETCH, 0), "sta_fetch");
        step(mk(0, 8'h25, 0, 0, E_NONE,  0), "sta_decode");
        step(mk(0, 8'h25, 0, 0, E_STA,   0), "sta_wait");
        step(mk(0, 8'h25, 1, 0, E_STA,   0), "sta_done");
        step(mk(0, 8'h25, 1, 0, E_FETCH, 0), "hlt_fetch");
        step(mk(0, 8'hF0, 1, 0, E_NONE,  0), "hlt_decode");
        for (int i = 0; i < 20; i++)
            step(mk(0, 8'hF0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    E_HALT, 0), $sformatf("halt%0d", i));
        step(mk(1, 8'hF0, 1, 0, E_NONE,  0), "hlt_rst");
        step(mk(0, 8'hF0, 0, 0, E_FWAIT, 0), "hlt_release");

        // Illegal opcode: NOP by default, trap when enabled
        step(mk(0, 8'h00, 1, 0, E_FETCH, 0), "ill_fetch");
        step(mk(0, 8'h9B, 1, 0, E_NONE,  0), "ill_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
        step(mk(0, 8'h9B, 1, 0, E_HALT,  1), "ill_trap0");
        step(mk(0, 8'h9B, 1, 0, E_HALT,  1), "ill_trap1");
        step(mk(1, 8'h9B, 1, 0, E_NONE,  0), "ill_rst");
        step(mk(0, 8'h9B, 0, 0, E_FWAIT, 0), "ill_release");
`else
        step(mk(0, 8'h9B, 1, 0, E_FETCH, 0), "ill_nop_fetch");
        step(mk(0, 8'hE1, 1, 0, E_NONE,  0), "ill_nop_decode");
        step(mk(0, 8'hE1, 0, 0, E_FWAIT, 0), "ill_nop_back");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Downstream consumer of the 8-bit instruction register in the tiny CPU.
- Multi-cycle fetch/decode/execute FSM. Drives the IR load strobe, PC control, memory read/write strobes, accumulator/ALU controls and the output-port strobe from the latched instruction.
- Single memory port with a ready handshake, so wait states are tolerated.

Parameters:
- INST_W, 8, instruction width (fixed format: opcode [7:4], operand [3:0]).
- OPC_W, 4, opcode field width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ir_inst  in  8  current instruction-register contents
- mem_ready  in  1  memory access completes this cycle
- zero_flag  in  1  accumulator == 0
- ir_load  out  1  IR captures memory data at next edge
- pc_inc  out  1  PC += 1
- pc_load  out  1  PC <= ir_inst[3:0]
- addr_sel  out  1  memory address: 0 = PC, 1 = ir_inst[3:0]
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request (data = ACC)
- acc_load  out  1  ACC captures selected source
- acc_src  out  1  0 = ALU result, 1 = zero-extended ir_inst[3:0]
- alu_op  out  2  00 PASS(mem), 01 ADD, 10 SUB
- out_load  out  1  output port captures ACC
- halted  out  1  FSM in HALT state

Behaviour:
- State register holds one of four states: FETCH, DECODE, MEM_RD, MEM_WR, plus HALT.
- Reset:
  - A clk edge with rst=1 puts the FSM in FETCH.
  - While rst=1, every output is forced to 0, including halted.
  - rst has priority over any access in progress. An in-flight access is abandoned with no strobes.
- Outputs are combinational from state, ir_inst, mem_ready and zero_flag. Any strobe not listed for a state is 0.
- FETCH:
  - Drives mem_rd=1, addr_sel=0.
  - If mem_ready=1: ir_load=1 and pc_inc=1 in the same cycle, next state DECODE.
  - Otherwise the FSM stays in FETCH with mem_rd held.
- DECODE: ir_inst is valid. Dispatch on opcode = ir_inst[7:4]:
  - 0 NOP: go to FETCH.
  - 1 LDA, 3 ADD, 4 SUB: go to MEM_RD.
  - 2 STA: go to MEM_WR.
  - 5 LDI: acc_load=1, acc_src=1; go to FETCH.
  - 6 JMP: pc_load=1; go to FETCH.
  - 7 JZ: pc_load=zero_flag; go to FETCH.
  - 8 OUT: out_load=1; go to FETCH.
  - F HLT: go to HALT.
  - 9-E: illegal, handled as NOP (see Optional Feature).
- MEM_RD:
  - Drives mem_rd=1, addr_sel=1.
  - alu_op = PASS for LDA, ADD for ADD, SUB for SUB.
  - On mem_ready=1: acc_load=1, acc_src=0; go to FETCH. Otherwise wait.
- MEM_WR:
  - Drives mem_wr=1, addr_sel=1.
  - On mem_ready=1: go to FETCH. Otherwise wait.
- HALT: halted=1, no strobes. Only rst leaves HALT.
- Latency with zero wait states:
  - NOP/LDI/JMP/JZ/OUT: 2 cycles.
  - LDA/ADD/SUB/STA: 3 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- Strobe exclusivity:
  - pc_inc and pc_load are never both 1.
  - mem_rd and mem_wr are never both 1.
- ir_inst must not change between DECODE and the end of MEM_RD or MEM_WR. This holds because ir_load is only asserted in FETCH.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes 9-E in DECODE go to HALT.
  - Adds output port illegal (1 bit). It is set to 1 on that transition and held until rst; its reset value is 0.
- Undefined:
  - Opcodes 9-E execute as NOP.
  - The illegal port does not exist.

Decomposition:
- Shared package ctrl_pkg:
  - State encoding constants (3 bits).
  - Opcode constants OP_NOP..OP_HLT.
  - ALU op constants ALU_PASS/ALU_ADD/ALU_SUB.
  - Field widths INST_W, OPC_W.
- Sub-module ctrl_decode (combinational):
  - Maps opcode to class: is_mem_rd, is_mem_wr, is_imm, is_jmp, is_jz, is_out, is_hlt, is_illegal, plus alu_op.
  - The sequencer keeps only the state register and the strobe logic.

Test Plan:
- Reset: rst=1 for 2 cycles mid-MEM_RD, then release → all outputs 0 during rst; first cycle after release shows mem_rd=1, addr_sel=0 (FETCH).
- LDI: mem_ready=1 always, fetch returns 0x57 → cycle 1 ir_load=pc_inc=1; cycle 2 acc_load=1, acc_src=1; cycle 3 back in FETCH.
- ADD with 2 wait states: IR=0x3A, mem_ready low 2 cycles in MEM_RD → mem_rd=1, addr_sel=1, alu_op=01 held 3 cycles; acc_load=1 only in the mem_ready cycle.
- JZ: IR=0x7C with zero_flag=0, then zero_flag=1 → pc_load=0, then pc_load=1; pc_inc never asserted in DECODE.
- STA then HLT: IR=0x25 → mem_wr=1, addr_sel=1 until ready; then IR=0xF0 → halted=1 and stays 1 for 20 cycles with no strobes.
- Illegal: IR=0x9x → NOP-like return to FETCH by default; with CTRL_ILLEGAL_TRAP_EN, halted=1 and illegal=1.
